// File: rtl/home_cmd_pkg.sv
// Shared types and constants for the home command sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package home_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GOT1     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_DISPATCH = 3'd3,
    ST_SHOW     = 3'd4
  } state_e;

  // PS/2 set-2 scan codes of interest
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Values handed to the home FSM / hex display
  localparam logic [7:0] VAL_OFF = 8'h00;
  localparam logic [7:0] VAL_ON  = 8'hFF;
  localparam logic [7:0] VAL_BAD = 8'h50;

  // Map a make code to its device/action value; unknown keys map to VAL_BAD.
  function automatic logic [7:0] decode_scan(input logic [7:0] code);
    case (code)
      SC_D:    decode_scan = VAL_OFF;
      SC_L:    decode_scan = VAL_ON;
      default: decode_scan = VAL_BAD;
    endcase
  endfunction

endpackage

// File: rtl/key_decode.sv
// Filters PS/2 break/extended prefixes and maps accepted make codes to values.
// Latency: combinational for make/value; break flag updates on the next edge.
// Backpressure: none; every qualified byte is consumed in its strobe cycle.
module key_decode
  import home_cmd_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code_i,
  input  logic       scan_valid_i,
  output logic       make_vld_o,
  output logic       esc_o,
  output logic [7:0] val_o,
  output logic       bad_o
);

  logic brk_q, brk_d;

  // Break-flag tracking and make-code qualification
  always_comb begin
    brk_d      = brk_q;
    make_vld_o = 1'b0;
    if (scan_valid_i) begin
      if (brk_q) begin
        // byte following F0 is the released key: drop it
        brk_d = 1'b0;
      end else if (scan_code_i == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (scan_code_i != SC_EXT) begin
        make_vld_o = 1'b1;
      end
    end
  end

  // Value mapping; Esc is flagged separately so the sequencer can treat it as abort
  always_comb begin
    esc_o = make_vld_o && (scan_code_i == SC_ESC);
    val_o = decode_scan(scan_code_i);
    bad_o = (scan_code_i != SC_D) && (scan_code_i != SC_L);
  end

  // Break flag register
  always_ff @(posedge clock) begin
    if (!resetn) brk_q <= 1'b0;
    else         brk_q <= brk_d;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Two-key + clap command sequencer: dispatches to home FSM or shows on HEX.
// Latency: command valid the cycle after the clap edge; held until cmd_ready.
// Backpressure: cmd_valid/cmd_ready; optional ARMED timeout via CLAP_TIMEOUT_EN.
module cmd_sequencer
  import home_cmd_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       clap,
  input  logic       select,
  output logic [7:0] cmd_val1,
  output logic [7:0] cmd_val2,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] hex_val1,
  output logic [7:0] hex_val2,
  output logic       hex_load,
  output logic       busy,
  output logic       err
);

  state_e     state_q, state_d;
  logic [7:0] key1_q, key2_q;
  logic [7:0] hex1_q, hex2_q;
  logic       err_q;

  logic       make_vld, esc;
  logic [7:0] key_val;
  logic       key_bad;
  logic       cap1, cap2, clr_keys, timeout;

  key_decode u_key_decode (
    .clock        (clock),
    .resetn       (resetn),
    .scan_code_i  (scan_code),
    .scan_valid_i (scan_valid),
    .make_vld_o   (make_vld),
    .esc_o        (esc),
    .val_o        (key_val),
    .bad_o        (key_bad)
  );

`ifdef CLAP_TIMEOUT_EN
  logic [31:0] cnt_q;

  // ARMED wait counter; sits at zero outside ARMED so it restarts on every entry
  always_ff @(posedge clock) begin
    if (!resetn)                  cnt_q <= 32'd0;
    else if (state_q == ST_ARMED) cnt_q <= cnt_q + 32'd1;
    else                          cnt_q <= 32'd0;
  end

  assign timeout = (state_q == ST_ARMED) && !esc && !clap &&
                   (cnt_q == (TIMEOUT_CYCLES - 32'd1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and key capture/clear decisions
  always_comb begin
    state_d  = state_q;
    cap1     = 1'b0;
    cap2     = 1'b0;
    clr_keys = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (make_vld && !esc) begin
          cap1    = 1'b1;
          state_d = ST_GOT1;
        end
      end
      ST_GOT1: begin
        if (esc) begin
          clr_keys = 1'b1;
          state_d  = ST_IDLE;
        end else if (make_vld) begin
          cap2    = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Esc has priority over a clap arriving in the same cycle
        if (esc || timeout) begin
          clr_keys = 1'b1;
          state_d  = ST_IDLE;
        end else if (clap) begin
          state_d = select ? ST_DISPATCH : ST_SHOW;
        end
      end
      ST_DISPATCH: begin
        if (cmd_ready) state_d = ST_IDLE;
      end
      ST_SHOW:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; command data forced to zero when not valid
  always_comb begin
    busy      = (state_q != ST_IDLE);
    cmd_valid = (state_q == ST_DISPATCH);
    cmd_val1  = cmd_valid ? key1_q : VAL_OFF;
    cmd_val2  = cmd_valid ? key2_q : VAL_OFF;
    hex_load  = (state_q == ST_SHOW);
    hex_val1  = hex1_q;
    hex_val2  = hex2_q;
    err       = err_q;
  end

  // Key, hex and error registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      key1_q <= VAL_OFF;
      key2_q <= VAL_OFF;
      hex1_q <= VAL_OFF;
      hex2_q <= VAL_OFF;
      err_q  <= 1'b0;
    end else begin
      err_q <= ((cap1 || cap2) && key_bad) || timeout;
      if (cap1) key1_q <= key_val;
      if (cap2) key2_q <= key_val;
      if (clr_keys) begin
        key1_q <= VAL_OFF;
        key2_q <= VAL_OFF;
      end
      // Hex display values change together with the hex_load strobe
      if (state_d == ST_SHOW) begin
        hex1_q <= key1_q;
        hex2_q <= key2_q;
      end
    end
  end

endmodule
